lif_frame_scheduler: RTL

Time-multiplexed controller that shares a single leaky-integrate-and-fire (LIF) update datapath among `N_NEURONS` neurons. It holds every neuron's membrane state in an internal register file. On each `start` it runs one frame: one neuron is updated per clock, in index order, from a snapshot of the input currents. At frame end it publishes the spike vector. It sits between the top-level pin mapping (currents from `ui_in`/`uio_in`, spikes to `uio_out`) and replaces per-neuron LIF instances.

---
 rtl/lif_frame_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/lif_frame_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath walks all neurons
// in index order per frame and publishes the frame's spike vector at the end.
module lif_frame_scheduler #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned THRESHOLD = 200
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic [N_NEURONS*WIDTH-1:0]   currents,
  input  logic [$clog2(N_NEURONS)-1:0] sel,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spikes,
  output logic [WIDTH-1:0]             state_out
);

  localparam int unsigned      IDXW     = $clog2(N_NEURONS);
  localparam int unsigned      SUMW     = WIDTH + 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N_NEURONS - 1);
  localparam logic [WIDTH-1:0] THRESH   = WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                       r_state;
  logic [IDXW-1:0]              r_idx;
  logic [N_NEURONS*WIDTH-1:0]   r_snap;
  logic [WIDTH-1:0]             r_mem [N_NEURONS];
  logic [N_NEURONS-1:0]         r_shadow;
  logic [N_NEURONS-1:0]         r_spikes;
  logic                         r_busy;
  logic                         r_done;

  logic [WIDTH-1:0]             w_cur [N_NEURONS];
  logic [WIDTH-1:0]             w_c;
  logic [WIDTH-1:0]             w_s;
  logic [SUMW-1:0]              w_sum;
  logic [WIDTH-1:0]             w_sat;
  logic                         w_fire;
  logic [WIDTH-1:0]             w_new;
  logic [N_NEURONS-1:0]         w_shadow_next;

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_unpack
    assign w_cur[k] = r_snap[k*WIDTH +: WIDTH];
  end

  // Shared LIF datapath for the neuron currently addressed by r_idx.
  always_comb begin
    w_c                  = w_cur[r_idx];
    w_s                  = r_mem[r_idx];
    w_sum                = SUMW'(w_c) + SUMW'(w_s >> 1);
    w_sat                = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    w_fire               = (w_sat >= THRESH);
    w_new                = w_fire ? '0 : w_sat;
    w_shadow_next        = r_shadow;
    w_shadow_next[r_idx] = w_fire;
  end

  // Frame sequencer, register file and registered outputs; ena=0 holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_snap   <= '0;
      r_shadow <= '0;
      r_spikes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        r_mem[k] <= '0;
      end
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_UPDATE;
            r_snap   <= currents;
            r_idx    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_UPDATE: begin
          r_mem[r_idx] <= w_new;
          r_shadow     <= w_shadow_next;
          r_idx        <= r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) begin
            r_state  <= S_DONE;
            r_spikes <= w_shadow_next;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign spikes    = r_spikes;
  assign state_out = r_mem[sel];

endmodule
